batt_mon: RTL and testbench

BATT_MON -- requirements
Module: batt_mon

---
 rtl/batt_mon.sv | 128 ++++++++++++
 tb/tb_batt_mon.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/batt_mon.sv
// Battery monitor: periodic / on-demand A2D conversions, 4-tap moving average,
// low (with hysteresis), sticky critical and sticky conversion-timeout flags.
//
// state | meaning
// IDLE  | waiting for period timer terminal count or a pending request
// CNV   | one-cycle strt_cnv pulse, timeout counter restarted
// WAIT  | waiting for cnv_cmplt or conversion timeout
// UPDT  | avg_vld pulse; filter and flags already hold the new result
module batt_mon #(
   parameter int         PERIOD_W = 20,
   parameter int         TMO_W    = 10,
   parameter logic [7:0] THR_LOW  = 8'hC0,
   parameter logic [7:0] THR_CRIT = 8'hA8,
   parameter logic [7:0] HYST     = 8'h04
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cnv_cmplt,
   input  logic [11:0] res,
   input  logic        meas_req,
   output logic        strt_cnv,
   output logic [7:0]  batt_avg,
   output logic        avg_vld,
   output logic        low_batt,
   output logic        crit_batt,
   output logic        a2d_err
);

   typedef enum logic [1:0] {IDLE, CNV, WAIT, UPDT} state_t;

   localparam logic [8:0] THR_REL = {1'b0, THR_LOW} + {1'b0, HYST};

   state_t              state_q, state_d;
   logic [PERIOD_W-1:0] per_cnt;
   logic [TMO_W-1:0]    tmo_cnt;
   logic                pending;
   logic                have_smpl;
   logic [11:0]         tap0, tap1, tap2, tap3;
   logic [13:0]         sum_q, sum_nxt;
   logic [7:0]          avg_nxt;
   logic                low_nxt;
   logic                cnv_go, smpl_take, tmo_hit;

   assign cnv_go    = (state_q == IDLE) && ((&per_cnt) || pending);
   assign smpl_take = (state_q == WAIT) && cnv_cmplt;
   assign tmo_hit   = (state_q == WAIT) && !cnv_cmplt && (&tmo_cnt);

   assign strt_cnv = (state_q == CNV);
   assign avg_vld  = (state_q == UPDT);
   assign batt_avg = sum_q[13:6];

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (cnv_go) state_d = CNV;
         CNV:  state_d = WAIT;
         WAIT: begin
            if (cnv_cmplt)
               state_d = UPDT;
            else if (&tmo_cnt)
               state_d = IDLE;
         end
         UPDT: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // The first sample preloads all taps, so the sum starts at 4*res.
   always_comb begin
      sum_nxt = {res, 2'b00};
      if (have_smpl)
         sum_nxt = sum_q + {2'b00, res} - {2'b00, tap3};
      avg_nxt = sum_nxt[13:6];
      low_nxt = low_batt;
      if (avg_nxt < THR_LOW)
         low_nxt = 1'b1;
      else if ({1'b0, avg_nxt} >= THR_REL)
         low_nxt = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         per_cnt <= '0;
         tmo_cnt <= '0;
         pending <= 1'b0;
      end else begin
         state_q <= state_d;
         per_cnt <= cnv_go ? '0 : per_cnt + 1'b1;
         tmo_cnt <= cnv_go ? '0 : tmo_cnt + 1'b1;
         // A request coinciding with CNV entry is kept rather than lost.
         if (meas_req)
            pending <= 1'b1;
         else if (cnv_go)
            pending <= 1'b0;
      end
   end

   // Filter and flags load on the cnv_cmplt edge so they are valid alongside avg_vld.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         have_smpl <= 1'b0;
         tap0      <= '0;
         tap1      <= '0;
         tap2      <= '0;
         tap3      <= '0;
         sum_q     <= '0;
         low_batt  <= 1'b0;
         crit_batt <= 1'b0;
         a2d_err   <= 1'b0;
      end else begin
         if (smpl_take) begin
            have_smpl <= 1'b1;
            tap0      <= res;
            tap1      <= have_smpl ? tap0 : res;
            tap2      <= have_smpl ? tap1 : res;
            tap3      <= have_smpl ? tap2 : res;
            sum_q     <= sum_nxt;
            low_batt  <= low_nxt;
            if (avg_nxt < THR_CRIT)
               crit_batt <= 1'b1;
         end
         if (tmo_hit)
            a2d_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_batt_mon.sv
// Testbench for batt_mon: directed scenarios plus randomized samples/latencies
// checked against a queue-based moving-average and flag model.
module tb_batt_mon;

   localparam int PW     = 4;
   localparam int TW     = 4;
   localparam int T_LOW  = 'hC0;
   localparam int T_CRIT = 'hA8;
   localparam int T_HYST = 'h04;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cnv_cmplt = 1'b0;
   logic [11:0] res = '0;
   logic        meas_req = 1'b0;
   logic        strt_cnv;
   logic [7:0]  batt_avg;
   logic        avg_vld;
   logic        low_batt;
   logic        crit_batt;
   logic        a2d_err;

   always #5 clk = ~clk;

   batt_mon #(
      .PERIOD_W (PW),
      .TMO_W    (TW),
      .THR_LOW  (8'hC0),
      .THR_CRIT (8'hA8),
      .HYST     (8'h04)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cnv_cmplt (cnv_cmplt),
      .res       (res),
      .meas_req  (meas_req),
      .strt_cnv  (strt_cnv),
      .batt_avg  (batt_avg),
      .avg_vld   (avg_vld),
      .low_batt  (low_batt),
      .crit_batt (crit_batt),
      .a2d_err   (a2d_err)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int last_strt = 0;

   logic [11:0] m_taps[$];
   bit          m_first;
   logic [7:0]  m_avg;
   logic        m_low, m_crit, m_err;

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_taps.delete();
      m_first = 1'b1;
      m_avg   = '0;
      m_low   = 1'b0;
      m_crit  = 1'b0;
      m_err   = 1'b0;
   endtask

   task automatic model_update(input logic [11:0] smp);
      int s;
      if (m_first) begin
         m_taps  = '{smp, smp, smp, smp};
         m_first = 1'b0;
      end else begin
         m_taps.push_back(smp);
         void'(m_taps.pop_front());
      end
      s = 0;
      foreach (m_taps[i]) s += int'(m_taps[i]);
      m_avg = 8'(s / 64);
      if (int'(m_avg) < T_LOW)
         m_low = 1'b1;
      else if (int'(m_avg) >= T_LOW + T_HYST)
         m_low = 1'b0;
      if (int'(m_avg) < T_CRIT)
         m_crit = 1'b1;
   endtask

   task automatic check_outs(input string tag);
      chk({tag, "_avg"},  32'(batt_avg),  32'(m_avg));
      chk({tag, "_low"},  32'(low_batt),  32'(m_low));
      chk({tag, "_crit"}, 32'(crit_batt), 32'(m_crit));
      chk({tag, "_err"},  32'(a2d_err),   32'(m_err));
   endtask

   task automatic wait_strt(output int gap);
      int n;
      n = 0;
      while (strt_cnv !== 1'b1 && n < 100) begin
         step();
         n++;
      end
      chk("strt_seen", 32'(strt_cnv), 32'd1);
      gap = cyc - last_strt;
      last_strt = cyc;
   endtask

   // Acts as the A2D: answers dly clocks after strt_cnv, optionally pulsing meas_req in WAIT.
   task automatic do_conv(input string tag, input logic [11:0] smp, input int dly,
                          input int exp_gap, input bit req3, output int gap);
      wait_strt(gap);
      if (exp_gap > 0) chk({tag, "_gap"}, 32'(gap), 32'(exp_gap));
      step();
      chk({tag, "_strt_1cyc"}, 32'(strt_cnv), 32'd0);
      for (int k = 1; k < dly; k++) begin
         meas_req = req3 && (k == 2 || k == 4 || k == 6);
         step();
      end
      meas_req  = 1'b0;
      cnv_cmplt = 1'b1;
      res       = smp;
      step();
      cnv_cmplt = 1'b0;
      res       = 12'($urandom);
      model_update(smp);
      chk({tag, "_vld"}, 32'(avg_vld), 32'd1);
      check_outs(tag);
      step();
      chk({tag, "_vld_1cyc"}, 32'(avg_vld), 32'd0);
   endtask

   initial begin
      int gap, prev_dly, dly, nvld, nstrt;
      logic [7:0]  exp40 [4];
      logic [11:0] smp;
      exp40 = '{8'hC8, 8'hC0, 8'hB8, 8'hB0};

      model_reset();
      step();
      step();
      chk("rst_strt", 32'(strt_cnv), 32'd0);
      chk("rst_vld",  32'(avg_vld),  32'd0);
      check_outs("rst");

      // First automatic conversion comes 2^PW clocks after release.
      rst_n = 1'b1;
      last_strt = cyc;
      do_conv("first", 12'hD00, 10, 16, 1'b0, gap);
      chk("first_avg_d0", 32'(batt_avg), 32'h0D0);
      for (int i = 0; i < 3; i++) do_conv("d00", 12'hD00, 10, 16, 1'b0, gap);

      for (int i = 0; i < 4; i++) begin
         do_conv("b00", 12'hB00, 10, 16, 1'b0, gap);
         chk("b00_step_avg", 32'(batt_avg), 32'(exp40[i]));
         chk("b00_step_low", 32'(low_batt), (i >= 2) ? 32'd1 : 32'd0);
      end

      for (int i = 0; i < 4; i++) do_conv("bc0", 12'hBC0, 10, 16, 1'b0, gap);
      chk("hyst_bc_avg", 32'(batt_avg), 32'h0BC);
      for (int i = 0; i < 4; i++) do_conv("c20", 12'hC20, 10, 16, 1'b0, gap);
      chk("hyst_c2_avg", 32'(batt_avg), 32'h0C2);
      chk("hyst_c2_low", 32'(low_batt), 32'd1);
      for (int i = 0; i < 4; i++) do_conv("c40", 12'hC40, 10, 16, 1'b0, gap);
      chk("hyst_c4_avg", 32'(batt_avg), 32'h0C4);
      chk("hyst_c4_low", 32'(low_batt), 32'd0);
      chk("hyst_c4_crit", 32'(crit_batt), 32'd0);

      for (int i = 0; i < 4; i++) do_conv("a00", 12'hA00, 10, 16, 1'b0, gap);
      chk("crit_set", 32'(crit_batt), 32'd1);
      for (int i = 0; i < 4; i++) do_conv("f00", 12'hF00, 10, 16, 1'b0, gap);
      chk("crit_sticky", 32'(crit_batt), 32'd1);

      // Immediate request from IDLE beats the period timer.
      meas_req = 1'b1;
      step();
      meas_req = 1'b0;
      do_conv("imm", 12'hE00, 10, 0, 1'b0, gap);
      chk("imm_early", 32'(gap < 16), 32'd1);

      // Randomized samples and A2D latencies; a conversion finishing after the
      // period timer wraps pushes the next automatic start a full period later.
      prev_dly = 10;
      for (int i = 0; i < 16; i++) begin
         smp = 12'($urandom_range(0, 4095));
         dly = $urandom_range(1, 14);
         do_conv("rnd", smp, dly, (prev_dly <= 13) ? 16 : 32, 1'b0, gap);
         prev_dly = dly;
      end

      // Conversion timeout: no answer from the A2D.
      wait_strt(gap);
      for (int k = 0; k < 15; k++) step();
      chk("tmo_before", 32'(a2d_err), 32'd0);
      step();
      m_err = 1'b1;
      check_outs("tmo");
      do_conv("after_tmo", 12'h900, 10, 32, 1'b0, gap);

      // Three requests during WAIT collapse into one extra conversion.
      do_conv("req3", 12'hD80, 10, 16, 1'b1, gap);
      do_conv("req_extra", 12'hD40, 10, 13, 1'b0, gap);
      do_conv("req_none", 12'hD20, 10, 16, 1'b0, gap);

      // Reset in the middle of WAIT.
      wait_strt(gap);
      for (int k = 0; k < 5; k++) step();
      rst_n = 1'b0;
      #1;
      chk("mid_rst_strt", 32'(strt_cnv),  32'd0);
      chk("mid_rst_vld",  32'(avg_vld),   32'd0);
      chk("mid_rst_avg",  32'(batt_avg),  32'd0);
      chk("mid_rst_low",  32'(low_batt),  32'd0);
      chk("mid_rst_crit", 32'(crit_batt), 32'd0);
      chk("mid_rst_err",  32'(a2d_err),   32'd0);
      model_reset();
      step();
      step();
      rst_n = 1'b1;
      last_strt = cyc;
      nvld  = 0;
      nstrt = 0;
      for (int k = 0; k < 15; k++) begin
         cnv_cmplt = (k == 3);
         res       = 12'h555;
         step();
         if (avg_vld === 1'b1) nvld++;
         if (strt_cnv === 1'b1) nstrt++;
      end
      cnv_cmplt = 1'b0;
      chk("late_cmplt_vld", 32'(nvld), 32'd0);
      chk("late_cmplt_strt", 32'(nstrt), 32'd0);
      chk("late_cmplt_avg", 32'(batt_avg), 32'd0);
      do_conv("post_rst", 12'hD00, 10, 16, 1'b0, gap);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
